// File: rtl/dbg_hart_ctrl.sv
// dbg_hart_ctrl: multi-hart debug command sequencer with ack timeout.
// Optional DBG_HALT_GROUP_EN: cmd_all broadcasts HALT/RESUME to all harts.
module dbg_hart_ctrl #(
  parameter int NUM_HARTS = 4,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int TMO_CYC   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [$clog2(NUM_HARTS):0]  cmd_hart,
  input  logic                        cmd_all,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [DATA_W-1:0]           cmd_wdata,
  output logic                        rsp_valid,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [NUM_HARTS-1:0]        enter_debug,
  output logic [NUM_HARTS-1:0]        req_halt,
  output logic [NUM_HARTS-1:0]        req_resume,
  output logic [NUM_HARTS-1:0]        step,
  input  logic [NUM_HARTS-1:0]        halted,
  input  logic [NUM_HARTS-1:0]        running,
  input  logic [NUM_HARTS-1:0]        stalled,
  output logic [NUM_HARTS-1:0]        dm_read,
  output logic [NUM_HARTS-1:0]        dm_write,
  output logic [ADDR_W-1:0]           dm_addr,
  output logic [DATA_W-1:0]           dm_wdata,
  input  logic [NUM_HARTS-1:0]        dm_access_valid,
  input  logic [NUM_HARTS*DATA_W-1:0] dm_rdata
);
  localparam int N  = NUM_HARTS;
  localparam int HW = $clog2(NUM_HARTS) + 1;
  localparam logic [HW-1:0] NH = HW'(NUM_HARTS);
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
`ifdef DBG_HALT_GROUP_EN
  localparam bit GRP = 1'b1;
`else
  localparam bit GRP = 1'b0;
`endif
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_HALT  = 3'd1;
  localparam logic [2:0] OP_RES   = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_READ  = 3'd4;
  localparam logic [2:0] OP_WRITE = 3'd5;

  typedef enum logic [2:0] {
    IDLE, HALT_W, RESUME_W, ACCESS, RESP
  } state_t;

  state_t state, state_n;

  logic [1:0]        rst_sync;
  logic              rst_q;
  logic [2:0]        op_q;
  logic [N-1:0]      sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_n, rd;
  logic [15:0]       cnt, cnt_n;
  logic              left_q, left_n;
  logic              err_q, err_n;

  // async assert, synchronous release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_q = rst_sync[1];

  logic         grp, c_ok, c_bad, c_hall;
  logic         h_ok, r_ok, a_ok;
  logic [N-1:0] c_sel;

  assign grp = GRP && cmd_all &&
               (cmd_op == OP_HALT || cmd_op == OP_RES);
  assign c_sel  = grp ? '1 : (N'(1) << cmd_hart);
  assign c_ok   = grp || (cmd_hart < NH);
  assign c_bad  = (cmd_op > OP_WRITE) ||
                  (!c_ok && cmd_op != OP_NOP);
  assign c_hall = ((halted & c_sel) == c_sel);
  assign h_ok   = !c_bad && cmd_op == OP_HALT;
  assign r_ok   = !c_bad &&
                  (cmd_op == OP_RES || cmd_op == OP_STEP);
  assign a_ok   = !c_bad &&
                  (cmd_op == OP_READ || cmd_op == OP_WRITE);

  logic hall, rall, hany, ack, tmo, is_step, r_done;

  assign hall    = ((halted & sel_q) == sel_q);
  assign rall    = ((running & sel_q) == sel_q);
  assign hany    = |(halted & sel_q);
  assign ack     = |(dm_access_valid & sel_q);
  assign tmo     = (cnt == TMO_LAST);
  assign is_step = (op_q == OP_STEP);
  // a step is done only once the hart has left and re-entered debug
  assign r_done  = is_step ? (left_q && hany) : rall;

  always_comb begin
    rd = '0;
    for (int i = 0; i < N; i++)
      if (sel_q[i]) rd = dm_rdata[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    left_n  = left_q;
    err_n   = err_q;
    rdata_n = rdata_q;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n = RESP;
          left_n  = 1'b0;
          err_n   = 1'b0;
          rdata_n = '0;
          unique case (1'b1)
            cmd_op == OP_NOP: begin
              err_n = 1'b0;
            end
            c_bad: begin
              err_n = 1'b1;
            end
            h_ok: begin
              if (!c_hall) state_n = HALT_W;
            end
            r_ok: begin
              if (c_hall) state_n = RESUME_W;
              else        err_n   = 1'b1;
            end
            a_ok: begin
              if (c_hall) state_n = ACCESS;
              else        err_n   = 1'b1;
            end
            default: begin
              err_n = 1'b1;
            end
          endcase
        end
      end
      HALT_W: begin
        if (hall) begin
          state_n = RESP;
        end else if (tmo) begin
          state_n = RESP;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RESUME_W: begin
        if (is_step) left_n = left_q | ~hany;
        if (r_done) begin
          state_n = RESP;
        end else if (tmo) begin
          state_n = RESP;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      ACCESS: begin
        if (ack) begin
          state_n = RESP;
          if (op_q == OP_READ) rdata_n = rd;
        end else if (tmo) begin
          state_n = RESP;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      state     <= IDLE;
      cnt       <= '0;
      left_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      op_q      <= OP_NOP;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      left_q  <= left_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
      if (state == IDLE && cmd_valid) begin
        op_q    <= cmd_op;
        sel_q   <= c_sel;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      rsp_valid <= (state == RESP);
      rsp_err   <= (state == RESP) && err_q;
      rsp_rdata <= (state == RESP) ? rdata_q : '0;
    end
  end

  logic in_h, in_r, in_a, first;

  assign in_h  = (state == HALT_W);
  assign in_r  = (state == RESUME_W);
  assign in_a  = (state == ACCESS);
  assign first = (cnt == 16'd0);

  assign cmd_ready   = (state == IDLE);
  assign req_halt    = in_h ? sel_q : '0;
  assign req_resume  = in_r ? sel_q : '0;
  assign step        = (in_r && is_step) ? sel_q : '0;
  assign enter_debug = (first && (in_h || (in_r && is_step)))
                       ? sel_q : '0;
  assign dm_read     = (in_a && op_q == OP_READ) ? sel_q : '0;
  assign dm_write    = (in_a && op_q == OP_WRITE) ? sel_q : '0;
  assign dm_addr     = in_a ? addr_q : '0;
  assign dm_wdata    = in_a ? wdata_q : '0;
endmodule

// File: tb/tb_dbg_hart_ctrl.sv
// tb_dbg_hart_ctrl: randomized bench with a transaction-level hart model.
// Predicts response timing and hart-side signals per command.
module tb_dbg_hart_ctrl;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_hart;
  logic         cmd_all;
  logic [6:0]   cmd_addr;
  logic [31:0]  cmd_wdata;
  logic         rsp_valid;
  logic         rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   enter_debug, req_halt, req_resume, step;
  logic [3:0]   halted, running, stalled;
  logic [3:0]   dm_read, dm_write;
  logic [6:0]   dm_addr;
  logic [31:0]  dm_wdata;
  logic [3:0]   dm_access_valid;
  logic [127:0] dm_rdata;

  int errors = 0;
  int checks = 0;
  logic [3:0] hv;

  dbg_hart_ctrl #(
    .NUM_HARTS(4), .ADDR_W(7), .DATA_W(32), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_hart(cmd_hart), .cmd_all(cmd_all),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .enter_debug(enter_debug), .req_halt(req_halt),
    .req_resume(req_resume), .step(step),
    .halted(halted), .running(running), .stalled(stalled),
    .dm_read(dm_read), .dm_write(dm_write),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_access_valid(dm_access_valid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bundle();
    return {enter_debug, req_halt, req_resume,
            step, dm_read, dm_write};
  endfunction

  task automatic set_harts();
    halted  = hv;
    running = ~hv;
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic run_txn(input logic [2:0] op,
                         input logic [2:0] hart,
                         input int d, input int e,
                         input logic [6:0] addr,
                         input logic [31:0] wd);
    logic [31:0] rd_arr [4];
    logic [3:0]  oh;
    logic [23:0] eb;
    logic [31:0] exp_rd;
    bit          vh, proceed, exp_err, act;
    int          hi, dn, r, w;
    vh = (hart < 3'd4);
    hi = int'(hart[1:0]);
    oh = vh ? (4'b0001 << hart[1:0]) : 4'b0000;
    for (int i = 0; i < 4; i++) rd_arr[i] = $urandom;
    dm_rdata = {rd_arr[3], rd_arr[2], rd_arr[1], rd_arr[0]};
    dm_access_valid = 4'($urandom) & ~oh;
    proceed = 0; exp_err = 0; exp_rd = 32'h0;
    if (op == 3'd0)               exp_err = 0;
    else if (op > 3'd5 || !vh)    exp_err = 1;
    else if (op == 3'd1)          proceed = !hv[hi];
    else begin
      proceed = hv[hi];
      exp_err = !hv[hi];
    end
    dn = (op == 3'd3) ? d + e : d;
    r = 2; w = 0;
    if (proceed) begin
      if (dn <= TMO) begin
        r = dn + 2; w = dn;
        if (op == 3'd4) exp_rd = rd_arr[hi];
      end else begin
        r = TMO + 2; w = TMO; exp_err = 1;
      end
    end
    chk("ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1; cmd_op = op; cmd_hart = hart;
    cmd_addr = addr; cmd_wdata = wd;
`ifdef DBG_HALT_GROUP_EN
    cmd_all = 1'b0;
`else
    cmd_all = 1'($urandom);
`endif
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    cmd_op = 3'($urandom); cmd_hart = 3'($urandom);
    cmd_addr = 7'($urandom); cmd_wdata = $urandom;
    for (int k = 1; k <= r; k++) begin
      act = (k <= w);
      eb = {(act && k == 1 && (op == 3'd1 || op == 3'd3)) ? oh : 4'h0,
            (act && op == 3'd1) ? oh : 4'h0,
            (act && (op == 3'd2 || op == 3'd3)) ? oh : 4'h0,
            (act && op == 3'd3) ? oh : 4'h0,
            (act && op == 3'd4) ? oh : 4'h0,
            (act && op == 3'd5) ? oh : 4'h0};
      chk("hart_sigs", 64'(bundle()), 64'(eb));
      chk("dm_addr", 64'(dm_addr),
          (act && (op == 3'd4 || op == 3'd5)) ? 64'(addr) : 64'd0);
      chk("rsp_valid", 64'(rsp_valid), 64'(k == r));
      chk("cmd_ready", 64'(cmd_ready), 64'(k == r));
      if (k == r) begin
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        if (op == 3'd5 && act)
          chk("dm_wdata", 64'(dm_wdata), 64'(wd));
      end
      if (proceed) begin
        if (op == 3'd1 && k == d) hv[hi] = 1'b1;
        if ((op == 3'd2 || op == 3'd3) && k == d) hv[hi] = 1'b0;
        if (op == 3'd3 && k == d + e) hv[hi] = 1'b1;
        if (op >= 3'd4 && k == d) dm_access_valid[hi] = 1'b1;
        set_harts();
      end
      if (op == 3'd5 && act && k == 1)
        chk("dm_wdata", 64'(dm_wdata), 64'(wd));
      if (k < r) @(negedge clk);
    end
    dm_access_valid = 4'h0;
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_hart = 0;
    cmd_all = 0; cmd_addr = 0; cmd_wdata = 0;
    stalled = 0; dm_access_valid = 0; dm_rdata = '0;
    hv = 4'h0;
    set_harts();
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_sigs", 64'(bundle()), 64'd0);
    chk("rst_addr", 64'(dm_addr), 64'd0);
    rst_n = 1;
    repeat (4) @(negedge clk);

    run_txn(3'd1, 3'd2, 3, 0, 7'h00, 32'h0);
    run_txn(3'd1, 3'd1, 1, 0, 7'h00, 32'h0);
    run_txn(3'd4, 3'd1, 2, 0, 7'h10, 32'h0);
    run_txn(3'd5, 3'd0, 1, 0, 7'h22, 32'h1234_5678);
    run_txn(3'd1, 3'd3, TMO + 4, 0, 7'h00, 32'h0);
    run_txn(3'd1, 3'd0, 2, 0, 7'h00, 32'h0);
    run_txn(3'd3, 3'd0, 2, 2, 7'h00, 32'h0);
    run_txn(3'd3, 3'd4, 1, 1, 7'h00, 32'h0);
    run_txn(3'd1, 3'd2, 1, 0, 7'h00, 32'h0);
    run_txn(3'd0, 3'd6, 1, 0, 7'h00, 32'h0);
    run_txn(3'd7, 3'd1, 1, 0, 7'h00, 32'h0);

    for (int n = 0; n < 200; n++) begin
      logic [2:0] op, hart;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) hv[i] = ~hv[i];
      set_harts();
      stalled = 4'($urandom);
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) hart = 3'($urandom_range(4, 7));
      else                           hart = 3'($urandom_range(0, 3));
      run_txn(op, hart, $urandom_range(1, TMO + 3),
              $urandom_range(1, 3), 7'($urandom), $urandom);
    end

    hv[1] = 1'b0;
    set_harts();
    chk("mid_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1; cmd_op = 3'd1; cmd_hart = 3'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    chk("mid_halt", 64'(req_halt), 64'h2);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_sigs", 64'(bundle()), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
    run_txn(3'd0, 3'd0, 1, 0, 7'h00, 32'h0);
    run_txn(3'd1, 3'd1, 2, 0, 7'h00, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
